// File: rtl/code_if.sv
// Keypad/status bundle for the code lock controller.
// master drives the keypad strobes, slave is the controller.
interface code_if;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       enter;
    logic       change;
    logic       open;
    logic       alarm;
    logic       neww;
    logic [1:0] fail_cnt;
    logic [2:0] digit_cnt;

    modport master (
        output key_valid, key_digit, enter, change,
        input  open, alarm, neww, fail_cnt, digit_cnt
    );

    modport slave (
        input  key_valid, key_digit, enter, change,
        output open, alarm, neww, fail_cnt, digit_cnt
    );
endinterface

// File: rtl/code_ctrl.sv
// Four-digit BCD code lock: open / reprogram / lockout Moore FSM.
// A single down-counter times both the OPEN and LOCKOUT dwell periods.
module code_ctrl #(
    parameter logic [15:0] DEFAULT_CODE = 16'h1234,
    parameter int          MAX_FAIL     = 3,
    parameter int          OPEN_CYCLES  = 500,
    parameter int          LOCK_CYCLES  = 1000
) (
    input  logic   clk,
    input  logic   rst,
    code_if.slave  bus
);
    localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_OPEN, S_PROG, S_LOCK} state_t;

    state_t        state_q, state_d;
    logic [15:0]   code_q, code_d;
    logic [15:0]   entry_q, entry_d;
    logic [2:0]    dcnt_q, dcnt_d;
    logic [1:0]    fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          open_q, open_d;
    logic          alarm_q, alarm_d;
    logic          neww_q, neww_d;

    logic       strobe;
    logic       match;
    logic       digit_ok;
    logic       timer_zero;
    logic [1:0] fail_inc;

    assign strobe     = bus.enter | bus.change;
    assign match      = (dcnt_q == 3'd4) && (entry_q == code_q);
    assign timer_zero = (timer_q == '0);
    assign fail_inc   = fail_q + 2'd1;
    // Digits are only taken when no submit strobe shares the cycle.
    assign digit_ok   = ((state_q == S_IDLE) || (state_q == S_PROG)) &&
                        bus.key_valid && (bus.key_digit <= 4'd9) &&
                        (dcnt_q < 3'd4) && !strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= DEFAULT_CODE;
            entry_q <= '0;
            dcnt_q  <= '0;
            fail_q  <= '0;
            timer_q <= '0;
            open_q  <= 1'b0;
            alarm_q <= 1'b0;
            neww_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            entry_q <= entry_d;
            dcnt_q  <= dcnt_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            open_q  <= open_d;
            alarm_q <= alarm_d;
            neww_q  <= neww_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    if (match)                          state_d = bus.enter ? S_OPEN : S_PROG;
                    else if (fail_inc == MAX_FAIL[1:0]) state_d = S_LOCK;
                end
            end
            S_OPEN:  if (bus.enter || timer_zero) state_d = S_IDLE;
            S_PROG:  if (strobe)                  state_d = S_IDLE;
            S_LOCK:  if (timer_zero)              state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        entry_d = entry_q;
        dcnt_d  = dcnt_q;
        code_d  = code_q;
        fail_d  = fail_q;
        timer_d = timer_q;

        if (strobe) begin
            entry_d = '0;
            dcnt_d  = '0;
        end else if (digit_ok) begin
            entry_d = {entry_q[11:0], bus.key_digit};
            dcnt_d  = dcnt_q + 3'd1;
        end

        if ((state_q == S_PROG) && bus.enter && (dcnt_q == 3'd4))
            code_d = entry_q;

        if ((state_q == S_IDLE) && strobe)
            fail_d = match ? 2'd0 : fail_inc;
        else if ((state_q == S_LOCK) && timer_zero)
            fail_d = 2'd0;

        // Load on entry so the state lasts exactly N cycles ending at count 0.
        if (state_d != state_q) begin
            if (state_d == S_OPEN)      timer_d = TW'(OPEN_CYCLES - 1);
            else if (state_d == S_LOCK) timer_d = TW'(LOCK_CYCLES - 1);
            else                        timer_d = '0;
        end else if (!timer_zero) begin
            timer_d = timer_q - 1'b1;
        end
    end

    always_comb begin
        open_d  = (state_d == S_OPEN);
        alarm_d = (state_d == S_LOCK);
        neww_d  = (state_d == S_PROG);
    end

    assign bus.open      = open_q;
    assign bus.alarm     = alarm_q;
    assign bus.neww      = neww_q;
    assign bus.fail_cnt  = fail_q;
    assign bus.digit_cnt = dcnt_q;
endmodule

// File: tb/tb_code_ctrl.sv
// Directed + randomized bench for code_ctrl against a digit-queue reference model.
module tb_code_ctrl;
    localparam int OPEN_C = 500;
    localparam int LOCK_C = 1000;
    localparam int MAXF   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    code_if bus();

    code_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: state is implied by remaining-cycle counters and a prog flag.
    int m_open_left;
    int m_lock_left;
    bit m_prog;
    int m_fail;
    int m_dig[$];
    int m_code[4];

    function automatic bit m_match();
        if (m_dig.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++) if (m_dig[i] != m_code[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic mstep(input bit kv, input int kd, input bit en, input bit ch, input bit r);
        bit take;
        take = kv && (kd <= 9) && !en && !ch && (m_dig.size() < 4);
        if (r) begin
            m_open_left = 0; m_lock_left = 0; m_prog = 0; m_fail = 0;
            m_dig.delete();
            m_code = '{1, 2, 3, 4};
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fail = 0;
        end else if (m_open_left > 0) begin
            if (en) m_open_left = 0;
            else    m_open_left--;
            if (en || ch) m_dig.delete();
        end else if (m_prog) begin
            if (en || ch) begin
                if (en && m_dig.size() == 4)
                    for (int i = 0; i < 4; i++) m_code[i] = m_dig[i];
                m_prog = 0;
                m_dig.delete();
            end else if (take) m_dig.push_back(kd);
        end else begin
            if (en || ch) begin
                if (m_match()) begin
                    m_fail = 0;
                    if (en) m_open_left = OPEN_C;
                    else    m_prog = 1;
                end else begin
                    m_fail++;
                    if (m_fail == MAXF) m_lock_left = LOCK_C;
                end
                m_dig.delete();
            end else if (take) m_dig.push_back(kd);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("%s differs: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit kv, input logic [3:0] kd, input bit en, input bit ch, input bit r);
        bus.key_valid = kv; bus.key_digit = kd; bus.enter = en; bus.change = ch; rst = r;
        @(posedge clk);
        mstep(kv, int'(kd), en, ch, r);
        #1;
        chk("open",      32'(bus.open),      32'(m_open_left > 0));
        chk("alarm",     32'(bus.alarm),     32'(m_lock_left > 0));
        chk("neww",      32'(bus.neww),      32'(m_prog));
        chk("fail_cnt",  32'(bus.fail_cnt),  32'(m_fail));
        chk("digit_cnt", 32'(bus.digit_cnt), 32'(m_dig.size()));
        bus.key_valid = 0; bus.enter = 0; bus.change = 0; rst = 0;
    endtask

    task automatic key(input int d);  cyc(1'b1, 4'(d), 1'b0, 1'b0, 1'b0); endtask
    task automatic ent();             cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); endtask
    task automatic chg();             cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); endtask
    task automatic idle(input int n); for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0); endtask
    task automatic keys4(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
    endtask

    initial begin
        bus.key_valid = 0; bus.key_digit = 0; bus.enter = 0; bus.change = 0; rst = 1;
        m_code = '{1, 2, 3, 4};
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'd5, 1'b1, 1'b1, 1'b1);
        chk("reset_open", 32'(bus.open), 0);
        chk("reset_dcnt", 32'(bus.digit_cnt), 0);

        // Correct code opens for exactly OPEN_C cycles
        keys4(1, 2, 3, 4);
        chk("dcnt4", 32'(bus.digit_cnt), 4);
        ent();
        chk("open_first", 32'(bus.open), 1);
        idle(OPEN_C - 1);
        chk("open_last", 32'(bus.open), 1);
        idle(1);
        chk("open_end", 32'(bus.open), 0);

        // Three failures -> lockout, keys ignored, fail_cnt cleared afterwards
        keys4(1, 2, 3, 5); ent();
        chk("fail1", 32'(bus.fail_cnt), 1);
        keys4(1, 2, 3, 5); ent();
        chk("fail2", 32'(bus.fail_cnt), 2);
        keys4(1, 2, 3, 5); ent();
        chk("alarm_on", 32'(bus.alarm), 1);
        keys4(1, 2, 3, 4); ent();
        chk("lock_keys", 32'(bus.digit_cnt), 0);
        chk("lock_stay", 32'(bus.alarm), 1);
        idle(LOCK_C - 6);
        chk("alarm_last", 32'(bus.alarm), 1);
        idle(1);
        chk("alarm_end", 32'(bus.alarm), 0);
        chk("fail_clr", 32'(bus.fail_cnt), 0);

        // Reprogram to 9876
        keys4(1, 2, 3, 4); chg();
        chk("prog_on", 32'(bus.neww), 1);
        keys4(9, 8, 7, 6); ent();
        chk("prog_off", 32'(bus.neww), 0);
        keys4(1, 2, 3, 4); ent();
        chk("old_code", 32'(bus.fail_cnt), 1);
        keys4(9, 8, 7, 6); ent();
        chk("new_code", 32'(bus.open), 1);
        ent();
        chk("open_early", 32'(bus.open), 0);

        // Reset restores default; short entry fails; fifth key dropped
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        key(1); key(2); key(3); ent();
        chk("short_fail", 32'(bus.fail_cnt), 1);
        keys4(1, 2, 3, 4); key(5);
        chk("fifth_drop", 32'(bus.digit_cnt), 4);
        ent();
        chk("open_after5", 32'(bus.open), 1);
        ent();

        // Invalid digit, enter+change together
        key(1); key(2); key(3); key(10);
        chk("hex_drop", 32'(bus.digit_cnt), 3);
        key(4);
        cyc(1'b1, 4'd7, 1'b1, 1'b1, 1'b0);
        chk("both_open", 32'(bus.open), 1);
        chk("both_noprog", 32'(bus.neww), 0);
        ent();

        // Reset during PROG after a reprogram
        keys4(1, 2, 3, 4); chg(); keys4(5, 5, 5, 5); ent();
        keys4(5, 5, 5, 5); chg();
        chk("prog_again", 32'(bus.neww), 1);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_prog", 32'(bus.neww), 0);
        keys4(1, 2, 3, 4); ent();
        chk("rst_code", 32'(bus.open), 1);
        ent();

        // Randomized episodes
        for (int ep = 0; ep < 40; ep++) begin
            int kind;
            kind = int'($urandom_range(0, 4));
            case (kind)
                0: begin
                    keys4(m_code[0], m_code[1], m_code[2], m_code[3]); ent();
                end
                1: begin
                    keys4(m_code[0], m_code[1], m_code[2], m_code[3]); chg();
                    for (int i = int'($urandom_range(0, 5)); i > 0; i--) key(int'($urandom_range(0, 11)));
                    if ($urandom_range(0, 1) == 1) ent(); else chg();
                end
                2: begin
                    for (int i = int'($urandom_range(0, 5)); i > 0; i--) key(int'($urandom_range(0, 15)));
                    if ($urandom_range(0, 1) == 1) ent(); else chg();
                end
                default: begin
                    for (int i = 0; i < 20; i++)
                        cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1'b0);
                end
            endcase
            if (m_open_left > 0) begin
                if ($urandom_range(0, 2) == 0) idle(m_open_left);
                else begin idle(int'($urandom_range(0, 5))); ent(); end
            end
            while (m_lock_left > 0)
                cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b0);
            idle(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/code_ctrl.md
CODE_CTRL -- requirements
Module: code_ctrl

Interface
REQ-001 Parameter DEFAULT_CODE, default 16'h1234: four BCD digits loaded as the stored code at reset, most significant digit entered first.
REQ-002 Parameter MAX_FAIL, default 3: consecutive failed attempts that trigger lockout (range 1-3).
REQ-003 Parameter OPEN_CYCLES, default 500: cycles the open output stays asserted.
REQ-004 Parameter LOCK_CYCLES, default 1000: cycles the lockout lasts.
REQ-005 Clock  input  1  sole clock; all state updates on the rising edge.
REQ-006 Reset  input  1  reset; synchronous and active-high.
REQ-007 key_valid  input  1  one-cycle strobe qualifying key_digit.
REQ-008 key_digit  input  4  keypad digit; values 0-9 are valid, 10-15 are ignored.
REQ-009 enter  input  1  one-cycle strobe that submits the current entry.
REQ-010 change  input  1  one-cycle strobe that submits the current entry as a request to reprogram the code.
REQ-011 open  output  1  high while in state OPEN.
REQ-012 alarm  output  1  high while in state LOCKOUT.
REQ-013 neww  output  1  high while in state PROG.
REQ-014 fail_cnt  output  2  count of consecutive failed attempts.
REQ-015 digit_cnt  output  3  number of digits held in the entry buffer (0-4).

Function
REQ-016 The block SHALL be a Moore FSM with states IDLE, OPEN, PROG and LOCKOUT; all outputs SHALL be registered and SHALL reflect a state change in the cycle after the triggering strobe.
REQ-017 In IDLE and PROG, an accepted digit (key_valid=1, key_digit<=9) SHALL shift the 16-bit entry buffer left by 4 bits, insert the digit at bits [3:0] and increment digit_cnt.
REQ-018 Digits SHALL be discarded when digit_cnt=4, when key_digit>9, in OPEN and LOCKOUT, and in any cycle where enter or change is also high.
REQ-019 If enter and change are high in the same cycle, enter SHALL take priority and change SHALL be ignored.
REQ-020 In IDLE, an attempt is a match when digit_cnt=4 and the entry buffer equals the stored code; any other condition is a failure.
REQ-021 IDLE with enter and a match: go to OPEN and clear fail_cnt.
REQ-022 IDLE with change and a match: go to PROG and clear fail_cnt.
REQ-023 IDLE with enter or change and a failure: increment fail_cnt; go to LOCKOUT if the new value equals MAX_FAIL, otherwise stay in IDLE.
REQ-024 Every enter or change in any state SHALL clear the entry buffer and set digit_cnt to 0.
REQ-025 OPEN SHALL last OPEN_CYCLES cycles and then return to IDLE; an enter strobe in OPEN SHALL return to IDLE early in the next cycle; change SHALL be ignored in OPEN.
REQ-026 PROG with enter and digit_cnt=4: load the entry buffer into the stored code and go to IDLE.
REQ-027 PROG with enter and digit_cnt<4, or with change: go to IDLE with the stored code unchanged; neither case SHALL count as a failure.
REQ-028 LOCKOUT SHALL ignore all inputs for LOCK_CYCLES cycles, then go to IDLE with fail_cnt cleared.
REQ-029 A single down-counter, wide enough for max(OPEN_CYCLES, LOCK_CYCLES), SHALL time both OPEN and LOCKOUT; it SHALL be loaded on state entry and its expiry SHALL be detected at count 0.
REQ-030 fail_cnt SHALL never exceed MAX_FAIL.

Reset
REQ-031 Reset=1 at a rising edge SHALL force IDLE, stored code=DEFAULT_CODE, entry buffer=0, digit_cnt=0, fail_cnt=0, timer=0, and open=alarm=neww=0; Reset SHALL take priority over all other inputs.
REQ-032 Reset asserted in OPEN, PROG or LOCKOUT SHALL abort that state immediately, and a code reprogrammed before reset SHALL revert to DEFAULT_CODE.

Verification
REQ-033 Keys 1,2,3,4 then enter -> open=1 from the next cycle for 500 cycles, then open=0 and state IDLE.
REQ-034 Keys 1,2,3,5 then enter, three times -> fail_cnt steps 1, 2, then alarm=1 for 1000 cycles; keys entered during lockout are ignored; afterwards fail_cnt=0.
REQ-035 Keys 1,2,3,4, change, keys 9,8,7,6, enter -> neww=1 during PROG; then 1,2,3,4 with enter is a failure and 9,8,7,6 with enter gives open=1.
REQ-036 Keys 1,2,3 then enter -> failure with fail_cnt=1; keys 1,2,3,4,5 then enter -> the fifth key is dropped, digit_cnt=4 and open=1.
REQ-037 enter and change in the same cycle after 1,2,3,4 -> OPEN and not PROG; key_valid with key_digit=4'hA -> digit_cnt unchanged.
REQ-038 Reset pulsed during PROG, after a prior successful reprogram -> neww=0 the next cycle and 1,2,3,4 with enter gives open=1.
